// File: rtl/eth_phy_10g_pkg.sv
// Shared types and helpers for the 10G PHY receive path.
// Holds the frame-sync state encoding and sync header classification.
package eth_phy_10g_pkg;

  typedef enum logic [1:0] {
    FS_HUNT,
    FS_LOCKED,
    FS_SLIP_HIGH,
    FS_SLIP_WAIT
  } fs_state_t;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  function automatic logic sh_is_valid(
    input logic [1:0] hdr
  );
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/eth_phy_10g_sat_counter.sv
// Saturating up-counter with asynchronous active-high clear.
// Holds at all-ones once reached; used for receive statistics.
module eth_phy_10g_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Count requested events, stopping at the maximum value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/eth_phy_10g_rx_frame_sync.sv
// 64b/66b receive block-lock engine: hunts via bitslip, tracks lock.
// Define ETH_PHY_RX_FRAME_SYNC_STATS_EN to build slip/invalid counters.
module eth_phy_10g_rx_frame_sync
  import eth_phy_10g_pkg::*;
#(
  parameter int HDR_WIDTH           = 2,
  parameter int BITSLIP_HIGH_CYCLES = 1,
  parameter int BITSLIP_LOW_CYCLES  = 8,
  parameter int SH_LOCK_COUNT       = 64,
  parameter int SH_INVALID_LIMIT    = 16
) (
  input  logic                 rx_clk,
  input  logic                 rx_rst,
  input  logic [HDR_WIDTH-1:0] serdes_rx_hdr,
  input  logic                 serdes_rx_hdr_valid,
  output logic                 serdes_rx_bitslip,
  output logic                 rx_block_lock,
  output logic                 rx_sh_invalid,
  output logic [7:0]           rx_slip_count,
  output logic [15:0]          rx_sh_invalid_count
);

  localparam int CNT_W = $clog2(SH_LOCK_COUNT) + 1;
  localparam int INV_W = $clog2(SH_INVALID_LIMIT) + 1;
  localparam int TMR_MAX =
    (BITSLIP_HIGH_CYCLES > BITSLIP_LOW_CYCLES) ?
    BITSLIP_HIGH_CYCLES : BITSLIP_LOW_CYCLES;
  localparam int TMR_W = $clog2(TMR_MAX + 1);

  localparam logic [CNT_W-1:0] LOCK_END =
    CNT_W'(SH_LOCK_COUNT);
  localparam logic [INV_W-1:0] INV_END =
    INV_W'(SH_INVALID_LIMIT);
  localparam logic [TMR_W-1:0] HIGH_END =
    TMR_W'(BITSLIP_HIGH_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOW_END =
    TMR_W'(BITSLIP_LOW_CYCLES - 1);

  fs_state_t        r_state;
  logic [CNT_W-1:0] r_sh_cnt;
  logic [INV_W-1:0] r_invld_cnt;
  logic [TMR_W-1:0] r_slip_timer;
  logic             r_bitslip;
  logic             r_lock;
  logic             r_sh_invalid;

  logic             w_qual;
  logic             w_hdr_ok;
  logic             w_invalid;
  logic [CNT_W-1:0] w_sh_cnt_inc;
  logic [INV_W-1:0] w_invld_inc;

  assign w_qual = serdes_rx_hdr_valid &&
    ((r_state == FS_HUNT) || (r_state == FS_LOCKED));
  assign w_hdr_ok     = sh_is_valid(serdes_rx_hdr[1:0]);
  assign w_invalid    = w_qual && !w_hdr_ok;
  assign w_sh_cnt_inc = r_sh_cnt + CNT_W'(1);
  assign w_invld_inc  = r_invld_cnt + INV_W'(1);

  // Block-lock state machine with registered status outputs.
  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      r_state      <= FS_HUNT;
      r_sh_cnt     <= '0;
      r_invld_cnt  <= '0;
      r_slip_timer <= '0;
      r_bitslip    <= 1'b0;
      r_lock       <= 1'b0;
      r_sh_invalid <= 1'b0;
    end else begin
      r_sh_invalid <= w_invalid;
      unique case (r_state)
        FS_HUNT: begin
          if (w_qual) begin
            if (!w_hdr_ok) begin
              r_sh_cnt     <= '0;
              r_slip_timer <= '0;
              r_bitslip    <= 1'b1;
              r_state      <= FS_SLIP_HIGH;
            end else if (w_sh_cnt_inc == LOCK_END) begin
              r_sh_cnt    <= '0;
              r_invld_cnt <= '0;
              r_lock      <= 1'b1;
              r_state     <= FS_LOCKED;
            end else begin
              r_sh_cnt <= w_sh_cnt_inc;
            end
          end
        end
        FS_LOCKED: begin
          if (w_qual) begin
            if (!w_hdr_ok && (w_invld_inc == INV_END)) begin
              r_sh_cnt     <= '0;
              r_invld_cnt  <= '0;
              r_slip_timer <= '0;
              r_lock       <= 1'b0;
              r_bitslip    <= 1'b1;
              r_state      <= FS_SLIP_HIGH;
            end else if (w_sh_cnt_inc == LOCK_END) begin
              r_sh_cnt    <= '0;
              r_invld_cnt <= '0;
            end else begin
              r_sh_cnt <= w_sh_cnt_inc;
              if (!w_hdr_ok) begin
                r_invld_cnt <= w_invld_inc;
              end
            end
          end
        end
        FS_SLIP_HIGH: begin
          if (r_slip_timer == HIGH_END) begin
            r_slip_timer <= '0;
            r_bitslip    <= 1'b0;
            r_state      <= FS_SLIP_WAIT;
          end else begin
            r_slip_timer <= r_slip_timer + TMR_W'(1);
          end
        end
        FS_SLIP_WAIT: begin
          if (r_slip_timer == LOW_END) begin
            r_slip_timer <= '0;
            r_sh_cnt     <= '0;
            r_invld_cnt  <= '0;
            r_state      <= FS_HUNT;
          end else begin
            r_slip_timer <= r_slip_timer + TMR_W'(1);
          end
        end
        default: begin
          r_state <= FS_HUNT;
        end
      endcase
    end
  end

  assign serdes_rx_bitslip = r_bitslip;
  assign rx_block_lock     = r_lock;
  assign rx_sh_invalid     = r_sh_invalid;

`ifdef ETH_PHY_RX_FRAME_SYNC_STATS_EN
  logic w_enter_slip;

  assign w_enter_slip = w_invalid &&
    ((r_state == FS_HUNT) || (w_invld_inc == INV_END));

  eth_phy_10g_sat_counter #(
    .WIDTH(8)
  ) u_slip_cnt (
    .i_clk   (rx_clk),
    .i_rst   (rx_rst),
    .i_inc   (w_enter_slip),
    .o_count (rx_slip_count)
  );

  eth_phy_10g_sat_counter #(
    .WIDTH(16)
  ) u_invld_cnt (
    .i_clk   (rx_clk),
    .i_rst   (rx_rst),
    .i_inc   (w_invalid),
    .o_count (rx_sh_invalid_count)
  );
`else
  assign rx_slip_count       = '0;
  assign rx_sh_invalid_count = '0;
`endif

endmodule
